// File: rtl/sa_input_skew_feeder_pkg.sv
// Shared types and defaults for the systolic-array input skew feeder.
// Imported by sa_delay_line and sa_input_skew_feeder.
package sa_pkg;

    typedef enum logic [1:0] {
        FEED_IDLE   = 2'd0,
        FEED_STREAM = 2'd1,
        FEED_DRAIN  = 2'd2
    } feed_state_e;

    localparam int SA_LEN_W       = 16;
    localparam int SA_NUM_ROWS    = 16;
    localparam int SA_INPUT_WIDTH = 32;

    // Drain counter must hold NUM_ROWS-1; never narrower than one bit.
    function automatic int drain_cnt_w(input int num_rows);
        return (num_rows > 1) ? $clog2(num_rows) : 1;
    endfunction

endpackage

// File: rtl/sa_input_skew_feeder_if.sv
// Activation-vector valid/ready stream into the skew feeder.
// The master drives vectors; the feeder is the slave.
interface sa_input_skew_feeder_if #(
    parameter int NUM_ROWS    = 16,
    parameter int INPUT_WIDTH = 32
);
    logic [NUM_ROWS-1:0][INPUT_WIDTH-1:0] vec_i;
    logic                                 vec_valid_i;
    logic                                 vec_ready_o;

    modport master (output vec_i, output vec_valid_i, input  vec_ready_o);
    modport slave  (input  vec_i, input  vec_valid_i, output vec_ready_o);
endinterface

// File: rtl/sa_input_skew_feeder_delay_line.sv
// DEPTH-stage data+valid register chain for one array row.
// SA_FEED_ZERO_FILL_EN: stages load zero data when their incoming valid is low.
module sa_delay_line
    import sa_pkg::*;
#(
    parameter int DEPTH = 1,
    parameter int WIDTH = SA_INPUT_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    input  logic             valid_i,
    output logic [WIDTH-1:0] d_o,
    output logic             valid_o
);

    logic [DEPTH-1:0][WIDTH-1:0] r_data;
    logic [DEPTH-1:0]            r_valid;
    logic [DEPTH:0][WIDTH-1:0]   w_data_chain;
    logic [DEPTH:0]              w_valid_chain;

    // Entry s of each chain is what stage s loads from.
    assign w_data_chain  = {r_data, d_i};
    assign w_valid_chain = {r_valid, valid_i};

    // Shift data and valid one stage per cycle.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_data  <= {(DEPTH*WIDTH){1'b0}};
            r_valid <= {DEPTH{1'b0}};
        end else begin
            for (int s = 0; s < DEPTH; s++) begin
                r_valid[s] <= w_valid_chain[s];
`ifdef SA_FEED_ZERO_FILL_EN
                r_data[s] <= w_valid_chain[s] ? w_data_chain[s] : {WIDTH{1'b0}};
`else
                if (w_valid_chain[s]) begin
                    r_data[s] <= w_data_chain[s];
                end
`endif
            end
        end
    end

    assign d_o     = r_data[DEPTH-1];
    assign valid_o = r_valid[DEPTH-1];

endmodule

// File: rtl/sa_input_skew_feeder.sv
// Skews activation vectors into a diagonal wavefront for the systolic array.
// Tile FSM and counters here; SA_FEED_ZERO_FILL_EN selects gap data behaviour in sa_delay_line.
module sa_input_skew_feeder
    import sa_pkg::*;
#(
    parameter int INPUT_WIDTH = SA_INPUT_WIDTH,
    parameter int NUM_ROWS    = SA_NUM_ROWS,
    parameter int LEN_W       = SA_LEN_W
) (
    input  logic                                 clk_i,
    input  logic                                 rst_n,
    input  logic                                 start_i,
    input  logic [LEN_W-1:0]                     len_i,
    sa_input_skew_feeder_if.slave                vec_if,
    output logic [NUM_ROWS-1:0][INPUT_WIDTH-1:0] input_o,
    output logic [NUM_ROWS-1:0]                  input_valid_o,
    output logic                                 busy_o,
    output logic                                 done_o
);

    localparam int                 DRAIN_W    = drain_cnt_w(NUM_ROWS);
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(NUM_ROWS - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_ONE  = DRAIN_W'(32'd1);
    localparam logic [DRAIN_W-1:0] DRAIN_ZERO = {DRAIN_W{1'b0}};
    localparam logic [LEN_W-1:0]   LEN_ONE    = LEN_W'(32'd1);
    localparam logic [LEN_W-1:0]   LEN_ZERO   = {LEN_W{1'b0}};

    feed_state_e        r_state;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   r_cnt;
    logic [DRAIN_W-1:0] r_drain;
    logic               r_vec_ready;
    logic               r_busy;
    logic               r_done;
    logic               w_accept;
    logic [LEN_W-1:0]   w_cnt_next;

    // Accept strobe and the count it produces; the compare on w_cnt_next stops before wrap.
    always_comb begin
        w_accept   = r_vec_ready & vec_if.vec_valid_i;
        w_cnt_next = r_cnt + LEN_ONE;
    end

    // Tile FSM with registered handshake and status outputs.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= FEED_IDLE;
            r_len       <= LEN_ZERO;
            r_cnt       <= LEN_ZERO;
            r_drain     <= DRAIN_ZERO;
            r_vec_ready <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                FEED_IDLE: begin
                    if (start_i) begin
                        r_len <= len_i;
                        r_cnt <= LEN_ZERO;
                        if (len_i != LEN_ZERO) begin
                            r_state     <= FEED_STREAM;
                            r_vec_ready <= 1'b1;
                            r_busy      <= 1'b1;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end
                FEED_STREAM: begin
                    if (w_accept) begin
                        r_cnt <= w_cnt_next;
                        if (w_cnt_next == r_len) begin
                            r_state     <= FEED_DRAIN;
                            r_vec_ready <= 1'b0;
                            r_drain     <= DRAIN_LOAD;
                        end
                    end
                end
                FEED_DRAIN: begin
                    if (r_drain == DRAIN_ZERO) begin
                        r_state <= FEED_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_drain <= r_drain - DRAIN_ONE;
                    end
                end
                default: begin
                    r_state     <= FEED_IDLE;
                    r_cnt       <= LEN_ZERO;
                    r_drain     <= DRAIN_ZERO;
                    r_vec_ready <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign vec_if.vec_ready_o = r_vec_ready;
    assign busy_o             = r_busy;
    assign done_o             = r_done;

    // Row r sees the accept strobe and its lane through r+1 registers.
    for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
        sa_delay_line #(
            .DEPTH (r + 1),
            .WIDTH (INPUT_WIDTH)
        ) u_delay (
            .clk_i   (clk_i),
            .rst_n   (rst_n),
            .d_i     (vec_if.vec_i[r]),
            .valid_i (w_accept),
            .d_o     (input_o[r]),
            .valid_o (input_valid_o[r])
        );
    end

endmodule
